mpu_store_sched: RTL and testbench

Round-robin scheduler that shares the single `mpu_store` unit (register file → external memory path) among `NUM_REQ` requesters such as the host interface and the multiply-result writeback. It accepts a matrix-register store request from each requester and grants one at a time. It drives `mpu_store` with a one-cycle request pulse and a held register address, then tracks the transfer by watching the store-enable strobe. It signals per-requester completion, with an optional watchdog that flags a transfer that never starts or never ends.

---
 rtl/mpu_store_sched_pkg.sv | 14 +
 rtl/mpu_store_sched_if.sv | 16 +
 rtl/mpu_store_sched_arbiter.sv | 27 ++
 rtl/mpu_store_sched.sv | 91 +++++++++
 tb/tb_mpu_store_sched.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mpu_store_sched_pkg.sv
// mpu_store_sched_pkg: shared state type, address width and scheduler defaults
package mpu_store_sched_pkg;
   localparam int MATRIX_REG_BITS = 4;
   localparam int STORE_ADDR_W = MATRIX_REG_BITS + 1;
   localparam int NUM_STORE_REQ = 4;
   localparam int STORE_TIMEOUT_CYCLES = 1024;
   typedef enum logic [2:0] {
      SCHED_IDLE,
      SCHED_ISSUE,
      SCHED_WAIT_START,
      SCHED_ACTIVE,
      SCHED_DONE
   } sched_state_e;
endpackage

// File: rtl/mpu_store_sched_if.sv
// mpu_store_sched_if: requester-side request/grant/completion bundle of the store scheduler
interface mpu_store_sched_if
   import mpu_store_sched_pkg::*;
#(
   parameter int NUM_REQ = NUM_STORE_REQ,
   parameter int ADDR_W = STORE_ADDR_W
);
   logic [NUM_REQ-1:0] req_in;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in;
   logic [NUM_REQ-1:0] grant_out;
   logic [NUM_REQ-1:0] done_out;
   logic [NUM_REQ-1:0] err_out;
   logic busy_out;
   modport master (output req_in, req_addr_in, input grant_out, done_out, err_out, busy_out);
   modport slave (input req_in, req_addr_in, output grant_out, done_out, err_out, busy_out);
endinterface

// File: rtl/mpu_store_sched_arbiter.sv
// mpu_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module mpu_rr_arbiter #(
   parameter int N = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic enable,
   output logic [N-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic valid
);
   // Scan from the farthest offset back to ptr so the nearest set request at or after ptr wins last.
   always_comb begin
      grant = '0;
      grant_idx = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (enable && req[(int'(ptr) + i) % N]) begin
            grant = '0;
            grant[(int'(ptr) + i) % N] = 1'b1;
            grant_idx = IDX_W'((int'(ptr) + i) % N);
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mpu_store_sched.sv
// mpu_store_sched: round-robin sharing of mpu_store among requesters; define MPU_STORE_SCHED_TIMEOUT_EN for the transfer watchdog
module mpu_store_sched
   import mpu_store_sched_pkg::*;
#(
   parameter int NUM_REQ = NUM_STORE_REQ,
   parameter int TIMEOUT_CYCLES = STORE_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   mpu_store_sched_if.slave bus,
   output logic store_req_out,
   output logic [STORE_ADDR_W-1:0] store_addr_out,
   input  logic store_en_in
);
   localparam int IDX_W = $clog2(NUM_REQ);
   sched_state_e state, state_d;
   logic [IDX_W-1:0] rr_ptr, win_idx;
   logic [NUM_REQ-1:0] win_grant, grant_q;
   logic [STORE_ADDR_W-1:0] addr_q;
   logic win_valid, timeout;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("mpu_store_sched: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
   end

   mpu_rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req(bus.req_in),
      .ptr(rr_ptr),
      .enable(state == SCHED_IDLE),
      .grant(win_grant),
      .grant_idx(win_idx),
      .valid(win_valid)
   );

`ifdef MPU_STORE_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] wd_cnt;
   logic err_q;
   assign timeout = (state == SCHED_WAIT_START || state == SCHED_ACTIVE) && wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
   assign bus.err_out = (state == SCHED_DONE && err_q) ? grant_q : '0;
   // Watchdog counts cycles in the current waiting state, restarts on any state change, and remembers a timeout exit.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         err_q <= 1'b0;
      end else begin
         wd_cnt <= (state_d == state && (state == SCHED_WAIT_START || state == SCHED_ACTIVE)) ? wd_cnt + 1'b1 : '0;
         err_q <= timeout;
      end
   end
`else
   assign timeout = 1'b0;
   assign bus.err_out = '0;
`endif

   // Next-state: arbitrate in idle, then follow the store-enable strobe through start and end of the transfer.
   always_comb begin
      state_d = state;
      unique case (state)
         SCHED_IDLE:       state_d = win_valid ? SCHED_ISSUE : SCHED_IDLE;
         SCHED_ISSUE:      state_d = SCHED_WAIT_START;
         SCHED_WAIT_START: state_d = timeout ? SCHED_DONE : store_en_in ? SCHED_ACTIVE : SCHED_WAIT_START;
         SCHED_ACTIVE:     state_d = (timeout || !store_en_in) ? SCHED_DONE : SCHED_ACTIVE;
         SCHED_DONE:       state_d = SCHED_IDLE;
         default:          state_d = SCHED_IDLE;
      endcase
   end

   // State register plus winner/address latch and pointer advance taken when leaving idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SCHED_IDLE;
         rr_ptr <= '0;
         grant_q <= '0;
         addr_q <= '0;
      end else begin
         state <= state_d;
         if (state == SCHED_IDLE && win_valid) begin
            grant_q <= win_grant;
            addr_q <= bus.req_addr_in[win_idx];
            rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end
      end
   end

   assign bus.grant_out = (state == SCHED_IDLE) ? '0 : grant_q;
   assign bus.done_out = (state == SCHED_DONE) ? grant_q : '0;
   assign bus.busy_out = state != SCHED_IDLE;
   assign store_req_out = state == SCHED_ISSUE;
   assign store_addr_out = addr_q;
endmodule

// File: tb/tb_mpu_store_sched.sv
// tb_mpu_store_sched: directed and randomized checks of mpu_store_sched against a transaction-level model
module tb_mpu_store_sched;
   import mpu_store_sched_pkg::*;
   localparam int N = 4;
   localparam int AW = STORE_ADDR_W;
   localparam int TO = 16;
`ifdef MPU_STORE_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, store_req_out, store_en_in;
   logic [AW-1:0] store_addr_out;
   int errors = 0, checks = 0, cycle = 0;
   int st_delay = 0, st_len = 0;
   bit fixed = 1'b1, stall = 1'b0, auto_req = 1'b0;
   logic [N-1:0] got_g[$];
   int got_t[$];

   mpu_store_sched_if #(.NUM_REQ(N), .ADDR_W(AW)) bus ();

   mpu_store_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .store_req_out(store_req_out),
      .store_addr_out(store_addr_out),
      .store_en_in(store_en_in)
   );

   always #5 clk = ~clk;

   // Reference model: owner of the store unit, its latched address, cycles since grant, and phase age.
   int m_owner = -1, m_ptr = 0, m_age = 0, m_ph = 0, m_w;
   bit m_started = 1'b0, m_end = 1'b0, m_err = 1'b0;
   logic [AW-1:0] m_addr = '0;

   // Advance the model once per clock using the inputs sampled at this edge.
   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_end = 0; m_err = 0; m_addr = '0; m_age = 0; m_started = 0; m_ph = 0;
      end else if (m_end) begin
         m_owner = -1; m_end = 0; m_err = 0;
      end else if (m_owner < 0) begin
         m_w = -1;
         for (int k = 0; k < N; k++) if (m_w < 0 && bus.req_in[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
         if (m_w >= 0) begin
            m_owner = m_w; m_addr = bus.req_addr_in[m_w]; m_ptr = (m_w + 1) % N;
            m_age = 0; m_started = 0; m_ph = 0;
         end
      end else begin
         if (m_age > 0) begin
            if (TO_EN && m_ph == TO - 1) begin m_end = 1; m_err = 1; end
            else if (!m_started && store_en_in) begin m_started = 1; m_ph = -1; end
            else if (m_started && !store_en_in) m_end = 1;
            m_ph++;
         end
         m_age++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
      end
   endtask

   function automatic logic [N-1:0] gq(input int k);
      return (got_g.size() > k) ? got_g[k] : '0;
   endfunction

   function automatic int tq(input int k);
      return (got_t.size() > k) ? got_t[k] : 0;
   endfunction

   task automatic tick();
      logic [N-1:0] g;
      @(negedge clk);
      cycle++;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      chk("grant", bus.grant_out, g);
      chk("done", bus.done_out, m_end ? g : '0);
      chk("err", bus.err_out, m_err ? g : '0);
      chk("busy", bus.busy_out, m_owner >= 0);
      chk("store_req", store_req_out, m_owner >= 0 && m_age == 0);
      chk("store_addr", store_addr_out, m_addr);
      if (rst) begin
         st_delay = 0; st_len = 0; store_en_in = 1'b0;
      end else begin
         if (st_delay > 0) begin
            st_delay--;
            if (st_delay == 0) store_en_in = 1'b1;
         end else if (store_en_in) begin
            st_len--;
            if (st_len == 0) store_en_in = 1'b0;
         end
         if (store_req_out && !stall) begin
            st_delay = fixed ? 3 : int'($urandom_range(1, 4));
            st_len = fixed ? 6 : int'($urandom_range(1, 6));
         end
      end
      for (int i = 0; i < N; i++) begin
         if (bus.req_in[i] && bus.done_out[i]) bus.req_in[i] = 1'b0;
         else if (auto_req && !bus.req_in[i] && $urandom_range(0, 3) == 0) begin
            bus.req_in[i] = 1'b1;
            bus.req_addr_in[i] = AW'($urandom);
         end
         if (auto_req && $urandom_range(0, 7) == 0) bus.req_addr_in[i] = AW'($urandom);
      end
   endtask

   task automatic collect(input int n);
      got_g.delete();
      got_t.delete();
      for (int k = 0; k < 500 && got_g.size() < n; k++) begin
         tick();
         if (store_req_out) begin
            got_g.push_back(bus.grant_out);
            got_t.push_back(cycle);
         end
      end
      chk("collect_count", got_g.size(), n);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         tick();
         ok = !bus.busy_out && bus.req_in == '0;
      end
      chk("idle_reached", ok, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      store_en_in = 1'b0;
      bus.req_in = '0;
      bus.req_addr_in = '0;
      repeat (3) tick();
      chk("reset_busy", bus.busy_out, 1'b0);
      chk("reset_grant", bus.grant_out, 4'b0000);
      chk("reset_addr", store_addr_out, 0);
      rst = 1'b0;
      tick();
      bus.req_addr_in[0] = AW'(3);
      bus.req_in = 4'b0001;
      tick();
      chk("single_store_req", store_req_out, 1'b1);
      chk("single_grant", bus.grant_out, 4'b0001);
      chk("single_addr", store_addr_out, 3);
      bus.req_addr_in[0] = AW'(5);
      repeat (9) tick();
      chk("single_no_early_done", bus.done_out, 4'b0000);
      chk("addr_stable", store_addr_out, 3);
      tick();
      chk("single_done", bus.done_out, 4'b0001);
      chk("done_addr", store_addr_out, 3);
      tick();
      chk("idle_after_done", bus.busy_out, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req_in = 4'b1111;
      collect(4);
      chk("fair_0", gq(0), 4'b0001);
      chk("fair_1", gq(1), 4'b0010);
      chk("fair_2", gq(2), 4'b0100);
      chk("fair_3", gq(3), 4'b1000);
      for (int k = 1; k < 4; k++) chk("fair_gap", tq(k) - tq(k - 1), 12);
      wait_idle();
      bus.req_in = 4'b0100;
      collect(1);
      chk("rot_setup", gq(0), 4'b0100);
      wait_idle();
      bus.req_in = 4'b1001;
      collect(2);
      chk("rot_first", gq(0), 4'b1000);
      chk("rot_second", gq(1), 4'b0001);
      wait_idle();
      bus.req_addr_in[0] = AW'(7);
      bus.req_in = 4'b0001;
      collect(1);
      repeat (5) tick();
      chk("mid_active_busy", bus.busy_out, 1'b1);
      chk("mid_active_en", store_en_in, 1'b1);
      rst = 1'b1;
      tick();
      chk("rst_grant", bus.grant_out, 4'b0000);
      chk("rst_busy", bus.busy_out, 1'b0);
      chk("rst_store_req", store_req_out, 1'b0);
      chk("rst_done", bus.done_out, 4'b0000);
      chk("rst_addr", store_addr_out, 0);
      rst = 1'b0;
      bus.req_in = 4'b1111;
      collect(1);
      chk("post_rst_grant", gq(0), 4'b0001);
      bus.req_in = 4'b0001;
      wait_idle();
`ifdef MPU_STORE_SCHED_TIMEOUT_EN
      stall = 1'b1;
      bus.req_in = 4'b0010;
      collect(1);
      repeat (16) tick();
      chk("to_not_yet", bus.done_out, 4'b0000);
      tick();
      chk("to_done", bus.done_out, 4'b0010);
      chk("to_err", bus.err_out, 4'b0010);
      stall = 1'b0;
      wait_idle();
`endif
      fixed = 1'b0;
      auto_req = 1'b1;
      repeat (3000) tick();
      auto_req = 1'b0;
      wait_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
